// File: rtl/conv_sched_pkg.sv
// Shared types and sizing helpers for the convolution row scheduler.
// Optional ReLU capture is selected with the CONV_SCHED_RELU_EN macro (see conv_result_capture).
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    OUTPUT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Serial MAC needs D*F*F products plus pipeline fill/drain.
  function automatic int calc_lat(input int d, input int f);
    return d * f * f + 2;
  endfunction

  function automatic int calc_out_h(input int img_h, input int f);
    return img_h - f + 1;
  endfunction

  localparam int DEF_LAT   = calc_lat(1, 5);
  localparam int DEF_OUT_H = calc_out_h(32, 5);
  localparam int DEF_CNT_W = $clog2(DEF_LAT + 1);
  localparam int DEF_ROW_W = $clog2(DEF_OUT_H);

endpackage

// File: rtl/conv_result_capture.sv
// Lane register bank that snapshots all conv-unit results for one output row.
// With CONV_SCHED_RELU_EN defined, each word with its sign bit set is stored as zero.
module conv_result_capture
  import conv_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_UNITS  = 28
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_en,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] din,
  output logic [NUM_UNITS*DATA_WIDTH-1:0] dout
);

  logic [NUM_UNITS*DATA_WIDTH-1:0] lane_val;
  logic [NUM_UNITS*DATA_WIDTH-1:0] data_d;
  logic [NUM_UNITS*DATA_WIDTH-1:0] data_q;

  // ReLU is purely combinational on the capture path, so it adds no latency.
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_lane
`ifdef CONV_SCHED_RELU_EN
    assign lane_val[gi*DATA_WIDTH +: DATA_WIDTH] =
      din[gi*DATA_WIDTH + DATA_WIDTH - 1] ? '0 : din[gi*DATA_WIDTH +: DATA_WIDTH];
`else
    assign lane_val[gi*DATA_WIDTH +: DATA_WIDTH] = din[gi*DATA_WIDTH +: DATA_WIDTH];
`endif
  end

  always_comb begin
    data_d = data_q;
    if (load_en) data_d = lane_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign dout = data_q;

endmodule

// File: rtl/conv_row_scheduler.sv
// Sequences a bank of parallel conv units one output row at a time: load window, run, capture, hand off.
// Build option CONV_SCHED_RELU_EN enables ReLU on captured results.
module conv_row_scheduler
  import conv_sched_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int D          = 1,
  parameter  int F          = 5,
  parameter  int IMG_H      = 32,
  parameter  int NUM_UNITS  = 28,
  localparam int OUT_H      = calc_out_h(IMG_H, F),
  localparam int ROW_W      = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int BUS_W      = NUM_UNITS * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             win_req,
  input  logic             win_ack,
  output logic [ROW_W-1:0] row_idx,
  output logic             unit_rst,
  input  logic [BUS_W-1:0] unit_result,
  output logic [BUS_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row
);

  localparam int LAT   = calc_lat(D, F);
  localparam int CNT_W = $clog2(LAT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_idx_q, row_idx_d;
  logic [ROW_W-1:0]   out_row_q, out_row_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               win_req_q, win_req_d;
  logic               unit_rst_q, unit_rst_d;
  logic               out_valid_q, out_valid_d;
  logic               capture_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_idx_d   = row_idx_q;
    out_row_d   = out_row_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    win_req_d   = win_req_q;
    unit_rst_d  = unit_rst_q;
    out_valid_d = out_valid_q;
    capture_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          row_idx_d = '0;
          busy_d    = 1'b1;
          win_req_d = 1'b1;
        end
      end
      LOAD: begin
        if (win_ack) begin
          state_d    = RUN;
          win_req_d  = 1'b0;
          unit_rst_d = 1'b0;
          cnt_d      = '0;
        end
      end
      RUN: begin
        // The capture edge is the one that closes the LAT-th run cycle.
        if (cnt_q == CNT_W'(LAT - 1)) begin
          state_d     = OUTPUT;
          capture_en  = 1'b1;
          out_row_d   = row_idx_q;
          out_valid_d = 1'b1;
          unit_rst_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (row_idx_q == ROW_W'(OUT_H - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = LOAD;
            row_idx_d = row_idx_q + 1'b1;
            win_req_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_idx_q   <= '0;
      out_row_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_req_q   <= 1'b0;
      unit_rst_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_idx_q   <= row_idx_d;
      out_row_q   <= out_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      win_req_q   <= win_req_d;
      unit_rst_q  <= unit_rst_d;
      out_valid_q <= out_valid_d;
    end
  end

  conv_result_capture #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_UNITS (NUM_UNITS)
  ) u_capture (
    .clk    (clk),
    .rst    (reset),
    .load_en(capture_en),
    .din    (unit_result),
    .dout   (out_data)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign win_req   = win_req_q;
  assign row_idx   = row_idx_q;
  assign unit_rst  = unit_rst_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench for conv_row_scheduler at default sizing (LAT=27, OUT_H=28).
// Expected ReLU lane value follows the CONV_SCHED_RELU_EN macro.
module tb_conv_row_scheduler;

  localparam int DW    = 32;
  localparam int NU    = 28;
  localparam int LAT   = 27;
  localparam int OUT_H = 28;
  localparam int ROW_W = 5;
  localparam int BUS_W = NU * DW;
  localparam int BOUND = 200;

`ifdef CONV_SCHED_RELU_EN
  localparam logic [DW-1:0] EXP_NEG = 32'h0;
`else
  localparam logic [DW-1:0] EXP_NEG = 32'hC000_0000;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic             done;
  logic             win_req;
  logic             win_ack;
  logic [ROW_W-1:0] row_idx;
  logic             unit_rst;
  logic [BUS_W-1:0] unit_result;
  logic [BUS_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;

  int checks = 0;
  int errors = 0;
  int run_cnt = 0;
  int last_run = 0;
  bit override_en = 1'b0;

  conv_row_scheduler #(
    .DATA_WIDTH(DW), .D(1), .F(5), .IMG_H(32), .NUM_UNITS(NU)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .win_req(win_req), .win_ack(win_ack), .row_idx(row_idx), .unit_rst(unit_rst),
    .unit_result(unit_result), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row)
  );

  always #5 clk = ~clk;

  // Conv-unit model: results are only meaningful after exactly LAT cycles out of reset.
  always @(negedge clk) begin
    if (unit_rst) begin
      if (run_cnt != 0) last_run <= run_cnt;
      run_cnt <= 0;
    end else begin
      run_cnt <= run_cnt + 1;
    end
  end

  always_comb begin
    unit_result = '0;
    for (int k = 0; k < NU; k++) begin
      if (run_cnt != LAT)
        unit_result[(NU-1-k)*DW +: DW] = 32'hBAD0_0000 | k;
      else if (override_en && k == 0)
        unit_result[(NU-1-k)*DW +: DW] = 32'hC000_0000;
      else if (override_en && k == 1)
        unit_result[(NU-1-k)*DW +: DW] = 32'h4000_0000;
      else
        unit_result[(NU-1-k)*DW +: DW] = int'(row_idx) * 100 + k;
    end
  end

  function automatic logic [BUS_W-1:0] exp_row(input int r, input bit ovr);
    logic [BUS_W-1:0] v;
    v = '0;
    for (int k = 0; k < NU; k++) begin
      if (ovr && k == 0)      v[(NU-1-k)*DW +: DW] = EXP_NEG;
      else if (ovr && k == 1) v[(NU-1-k)*DW +: DW] = 32'h4000_0000;
      else                    v[(NU-1-k)*DW +: DW] = r * 100 + k;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_win_req"}, win_req, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_unit_rst"}, unit_rst, 1);
    check({tag, "_row_idx"}, row_idx, 0);
    check({tag, "_out_row"}, out_row, 0);
    check_data({tag, "_out_data"}, out_data, '0);
  endtask

  task automatic wait_win_req(output int waited);
    waited = 0;
    while (!win_req && waited < BOUND) begin
      @(negedge clk);
      waited++;
    end
    check("win_req_seen", win_req, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full row: window handshake, run, capture check, optional stall, output handshake.
  task automatic run_row(input int r, input int stall, input bit poke_start, input bit first, input bit ovr);
    int w, lat;
    bit stable, held, quiet;
    logic [BUS_W-1:0] snap;
    wait_win_req(w);
    if (!first) check($sformatf("row%0d_b2b_win_req", r), w, 0);
    check($sformatf("row%0d_row_idx", r), row_idx, r);
    check($sformatf("row%0d_load_unit_rst", r), unit_rst, 1);
    @(negedge clk);
    win_ack = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      win_ack = 1'b0;
      lat++;
      start = (poke_start && lat == 3);
    end while (!out_valid && lat < BOUND);
    start = 1'b0;
    check($sformatf("row%0d_latency", r), lat, LAT + 1);
    check($sformatf("row%0d_out_row", r), out_row, r);
    check_data($sformatf("row%0d_data", r), out_data, exp_row(r, ovr));
    if (poke_start) check($sformatf("row%0d_busy_after_start", r), busy, 1);
    if (stall > 0) begin
      stable = 1'b1; held = 1'b1; quiet = 1'b1;
      snap = out_data;
      repeat (stall) begin
        @(negedge clk);
        if (!out_valid || out_data !== snap || out_row !== ROW_W'(r)) stable = 1'b0;
        if (!unit_rst) held = 1'b0;
        if (win_req) quiet = 1'b0;
      end
      check($sformatf("row%0d_stall_stable", r), stable, 1);
      check($sformatf("row%0d_stall_unit_rst", r), held, 1);
      check($sformatf("row%0d_stall_no_win_req", r), quiet, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("row%0d_valid_drop", r), out_valid, 0);
    check($sformatf("row%0d_run_len", r), last_run, LAT);
  endtask

  initial begin
    int w, dones;
    reset = 1'b1; start = 1'b0; win_ack = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Layer 1: full pass, stall on row 3, spurious start during row 5.
    pulse_start();
    check("l1_busy", busy, 1);
    for (int r = 0; r < OUT_H; r++)
      run_row(r, (r == 3) ? 10 : 0, r == 5, r == 0, 1'b0);
    check("l1_done_pulse", done, 1);
    check("l1_done_busy", busy, 1);
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("l1_single_done", dones, 0);
    check("l1_idle_busy", busy, 0);
    check("l1_idle_win_req", win_req, 0);

    // Layer 2: reset in the middle of row 7.
    pulse_start();
    for (int r = 0; r < 7; r++) run_row(r, 0, 1'b0, r == 0, 1'b0);
    wait_win_req(w);
    check("row7_b2b_win_req", w, 0);
    check("row7_row_idx", row_idx, 7);
    @(negedge clk);
    win_ack = 1'b1;
    @(negedge clk);
    win_ack = 1'b0;
    repeat (11) @(negedge clk);
    check("row7_running", unit_rst, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midrun_reset");
    reset = 1'b0;
    @(negedge clk);

    // Layer 3: restart at row 0 with sign-test lanes.
    override_en = 1'b1;
    pulse_start();
    run_row(0, 0, 1'b0, 1'b1, 1'b1);
    override_en = 1'b0;
    run_row(1, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("final_reset");
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
